// File: rtl/huff_bit_packer.sv
// Packs variable-length Huffman codes MSB-first into bytes, zero-padding the final byte.
// Optional code-bit statistics on total_bits are enabled by defining HUFF_PACK_STATS_EN.
module huff_bit_packer #(
  parameter int unsigned CODE_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              code_valid,
  output logic              code_ready,
  input  logic [CODE_W-1:0] code_value,
  input  logic [CODE_W-1:0] code_mask,
  input  logic              code_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic              out_last,
  output logic [2:0]        out_pad,
  output logic              done,
  output logic [15:0]       total_bits
);

  localparam int unsigned ACC_W = 8 + CODE_W;
  localparam int unsigned CNT_W = $clog2(ACC_W + 1);
  localparam int unsigned LEN_W = $clog2(CODE_W + 1);

  typedef enum logic [1:0] {StAccum, StFlush, StDone} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d, acc_base, code_bits;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_base, shamt;
  logic [LEN_W-1:0]   code_len;
  logic               run_q;
  logic               code_xfer, byte_xfer;

  // Mask is contiguous from bit 0, so its popcount is the code length.
  always_comb begin
    code_len = '0;
    for (int i = 0; i < CODE_W; i++) begin
      code_len = code_len + LEN_W'(code_mask[i]);
    end
  end

  assign code_bits  = ACC_W'(code_value & code_mask);
  assign code_ready = run_q && (state_q == StAccum) && (cnt_q < CNT_W'(8));
  assign out_valid  = ((state_q == StAccum) && (cnt_q >= CNT_W'(8))) ||
                      ((state_q == StFlush) && (cnt_q != '0));
  assign out_last   = (state_q == StFlush) && (cnt_q != '0) && (cnt_q <= CNT_W'(8));
  assign out_pad    = out_last ? 3'(CNT_W'(8) - cnt_q) : 3'd0;
  assign out_byte   = acc_q[ACC_W-1 -: 8];
  assign done       = (state_q == StDone);
  assign code_xfer  = code_valid && code_ready;
  assign byte_xfer  = out_valid && out_ready;

  // Accumulator is MSB-aligned: the next byte to emit always sits in the top 8 bits.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    acc_base = byte_xfer ? (acc_q << 8) : acc_q;
    cnt_base = byte_xfer ? (cnt_q - CNT_W'(8)) : cnt_q;
    shamt    = CNT_W'(ACC_W) - cnt_base - CNT_W'(code_len);
    unique case (state_q)
      StAccum: begin
        acc_d = acc_base;
        cnt_d = cnt_base;
        if (code_xfer) begin
          acc_d = acc_base | (code_bits << shamt);
          cnt_d = cnt_base + CNT_W'(code_len);
          if (code_last) state_d = StFlush;
        end
      end
      StFlush: begin
        if (cnt_q == '0) begin
          state_d = StDone;
        end else if (byte_xfer) begin
          if (out_last) begin
            acc_d   = '0;
            cnt_d   = '0;
            state_d = StDone;
          end else begin
            acc_d = acc_base;
            cnt_d = cnt_base;
          end
        end
      end
      StDone: begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = StAccum;
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StAccum;
      acc_q   <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      run_q   <= 1'b1;
    end
  end

`ifdef HUFF_PACK_STATS_EN
  logic [15:0] total_q;
  logic        clr_q;
  logic [16:0] total_sum;

  assign total_sum  = {1'b0, total_q} + 17'(code_len);
  assign total_bits = total_q;

  // Count is held through DONE and restarts with the next message's first code.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      total_q <= '0;
      clr_q   <= 1'b0;
    end else begin
      if (state_q == StDone) clr_q <= 1'b1;
      if (code_xfer) begin
        clr_q <= 1'b0;
        if (clr_q)              total_q <= 16'(code_len);
        else if (total_sum[16]) total_q <= 16'hFFFF;
        else                    total_q <= total_sum[15:0];
      end
    end
  end
`else
  assign total_bits = '0;
`endif

endmodule

// File: tb/tb_huff_bit_packer.sv
// Self-checking bench for huff_bit_packer: directed table, hand-written corner cases,
// and randomized messages against a bit-queue reference model.
module tb_huff_bit_packer;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          code_valid = 1'b0;
  logic          code_ready;
  logic [CW-1:0] code_value = '0;
  logic [CW-1:0] code_mask = '0;
  logic          code_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [7:0]    out_byte;
  logic          out_last;
  logic [2:0]    out_pad;
  logic          done;
  logic [15:0]   total_bits;

  huff_bit_packer #(.CODE_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .code_value (code_value),
    .code_mask  (code_mask),
    .code_last  (code_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_byte   (out_byte),
    .out_last   (out_last),
    .out_pad    (out_pad),
    .done       (done),
    .total_bits (total_bits)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic       l;
    logic [2:0] p;
  } ob_t;

  typedef struct {
    int              n;
    logic [0:4][7:0] v;
    logic [0:4][7:0] m;
    int              nb;
    logic [0:1][7:0] b;
    logic [2:0]      pad;
    int              total;
  } dir_t;

  ob_t           got_q[$];
  ob_t           exp_q[$];
  logic [CW-1:0] mv[$];
  logic [CW-1:0] mm[$];
  dir_t          tbl[6];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  bit rand_ready = 1'b0;
  bit ready_force = 1'b1;

  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  always @(negedge clk) begin
    if (reset) begin
      if (out_valid && out_ready) got_q.push_back('{out_byte, out_last, out_pad});
      if (done) done_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic send_code(input logic [CW-1:0] v, input logic [CW-1:0] m, input logic l);
    int n = 0;
    code_valid = 1'b1;
    code_value = v;
    code_mask  = m;
    code_last  = l;
    @(negedge clk);
    while (!code_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!code_ready) timeout_fail("code_ready");
    @(posedge clk);
    #1;
    code_valid = 1'b0;
    code_last  = 1'b0;
  endtask

  task automatic wait_done(input int start);
    int n = 0;
    while (done_cnt == start && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == start) timeout_fail("done");
  endtask

  task automatic send_msg(input string tag);
    int start = done_cnt;
    got_q.delete();
    for (int k = 0; k < mv.size(); k++) send_code(mv[k], mm[k], k == mv.size() - 1);
    wait_done(start);
    repeat (3) @(negedge clk);
    check({tag, " done_pulses"}, done_cnt - start, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic compare_out(input string tag, input int exp_total);
    int n;
    check({tag, " byte_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s byte[%0d]", tag, i), got_q[i].b, exp_q[i].b);
      check($sformatf("%s last[%0d]", tag, i), got_q[i].l, exp_q[i].l);
      check($sformatf("%s pad[%0d]", tag, i), got_q[i].p, exp_q[i].p);
    end
`ifdef HUFF_PACK_STATS_EN
    check({tag, " total_bits"}, total_bits, exp_total);
`else
    check({tag, " total_bits"}, total_bits, 0);
`endif
  endtask

  // Reference: flatten all code bits MSB-first into a queue, then cut into bytes.
  function automatic int model_build();
    bit   bits[$];
    int   total = 0;
    logic [7:0] b;
    int   n;
    bit   lst;
    exp_q.delete();
    for (int k = 0; k < mv.size(); k++) begin
      int len = $countones(mm[k]);
      total += len;
      for (int i = len - 1; i >= 0; i--) bits.push_back(mv[k][i]);
    end
    while (bits.size() > 0) begin
      b = 8'h00;
      n = (bits.size() < 8) ? bits.size() : 8;
      for (int i = 0; i < n; i++) b[7-i] = bits.pop_front();
      lst = (bits.size() == 0);
      exp_q.push_back('{b, lst, lst ? 3'((8 - n) % 8) : 3'd0});
    end
    return (total > 65535) ? 65535 : total;
  endfunction

  task automatic run_table_entry(input int t, input string tag);
    mv.delete();
    mm.delete();
    exp_q.delete();
    for (int k = 0; k < tbl[t].n; k++) begin
      mv.push_back(tbl[t].v[k]);
      mm.push_back(tbl[t].m[k]);
    end
    for (int j = 0; j < tbl[t].nb; j++)
      exp_q.push_back('{tbl[t].b[j], j == tbl[t].nb - 1,
                        (j == tbl[t].nb - 1) ? tbl[t].pad : 3'd0});
    send_msg(tag);
    compare_out(tag, tbl[t].total);
  endtask

  initial begin
    int start;
    int exp_total;
    tbl[0] = '{3, {8'h05, 8'h02, 8'h01, 8'h00, 8'h00}, {8'h07, 8'h03, 8'h03, 8'h00, 8'h00},
               1, {8'hB2, 8'h00}, 3'd1, 7};
    tbl[1] = '{2, {8'hFF, 8'h00, 8'h00, 8'h00, 8'h00}, {8'hFF, 8'h0F, 8'h00, 8'h00, 8'h00},
               2, {8'hFF, 8'h00}, 3'd4, 12};
    tbl[2] = '{5, {8'h00, 8'h01, 8'h00, 8'h03, 8'h00}, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
               0, {8'h00, 8'h00}, 3'd0, 0};
    tbl[3] = '{1, {8'hA5, 8'h00, 8'h00, 8'h00, 8'h00}, {8'hFF, 8'h00, 8'h00, 8'h00, 8'h00},
               1, {8'hA5, 8'h00}, 3'd0, 8};
    tbl[4] = '{2, {8'h05, 8'h01, 8'h00, 8'h00, 8'h00}, {8'h07, 8'h01, 8'h00, 8'h00, 8'h00},
               1, {8'hB0, 8'h00}, 3'd4, 4};
    tbl[5] = '{3, {8'h3F, 8'h7F, 8'h01, 8'h00, 8'h00}, {8'h3F, 8'h7F, 8'h01, 8'h00, 8'h00},
               2, {8'hFF, 8'hFC}, 3'd2, 14};

    // Reset state
    #12;
    check("rst code_ready", code_ready, 0);
    check("rst out_valid", out_valid, 0);
    check("rst out_byte", out_byte, 0);
    check("rst out_last", out_last, 0);
    check("rst out_pad", out_pad, 0);
    check("rst done", done, 0);
    check("rst total_bits", total_bits, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("code_ready after reset", code_ready, 1);
    @(posedge clk);
    #1;

    for (int t = 0; t < 6; t++) run_table_entry(t, $sformatf("tbl%0d", t));

    // Output stall with 8 bits held
    ready_force = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    got_q.delete();
    start = done_cnt;
    send_code(8'hAB, 8'hFF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall out_valid c%0d", i), out_valid, 1);
      check($sformatf("stall code_ready c%0d", i), code_ready, 0);
      check($sformatf("stall out_byte c%0d", i), out_byte, 8'hAB);
      check($sformatf("stall out_last c%0d", i), out_last, 0);
    end
    ready_force = 1'b1;
    @(posedge clk);
    #1;
    send_code(8'h03, 8'h03, 1'b1);
    wait_done(start);
    repeat (3) @(negedge clk);
    check("stall done_pulses", done_cnt - start, 1);
    exp_q.delete();
    exp_q.push_back('{8'hAB, 1'b0, 3'd0});
    exp_q.push_back('{8'hC0, 1'b1, 3'd6});
    compare_out("stall", 10);
    @(posedge clk);
    #1;

    // Reset mid-message discards partial bits
    got_q.delete();
    send_code(8'h0F, 8'h0F, 1'b0);
    send_code(8'h03, 8'h03, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("midrst code_ready", code_ready, 0);
    check("midrst out_valid", out_valid, 0);
    check("midrst out_byte", out_byte, 0);
    check("midrst done", done, 0);
    check("midrst total_bits", total_bits, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    run_table_entry(0, "after_rst");

    // Randomized messages with random downstream backpressure
    rand_ready = 1'b1;
    for (int r = 0; r < 25; r++) begin
      int ncodes = $urandom_range(1, 6);
      mv.delete();
      mm.delete();
      for (int k = 0; k < ncodes; k++) begin
        int len = $urandom_range(0, CW);
        logic [CW-1:0] m = CW'((32'd1 << len) - 1);
        mm.push_back(m);
        mv.push_back(CW'($urandom()) & m);
      end
      exp_total = model_build();
      send_msg($sformatf("rnd%0d", r));
      compare_out($sformatf("rnd%0d", r), exp_total);
    end
    rand_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
